// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   - State encoding for the controller FSM (IDLE/RUN/DONE).
//   - Packed {E,G,L} result type and its equal/reset value.
package cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

  // Exactly one field is set at any time.
  typedef struct packed {
    logic e;
    logic g;
    logic l;
  } cmp_res_t;

  localparam cmp_res_t ResEqual = '{e: 1'b1, g: 1'b0, l: 1'b0};

endpackage

// File: rtl/digit_cmp.sv
// Combinational DIGIT-bit unsigned magnitude comparator.
// Ports:
//   x, y : DIGIT-bit digits to compare
//   E    : x == y
//   G    : x >  y
//   L    : x <  y
module digit_cmp #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             E,
  output logic             G,
  output logic             L
);

  assign E = (x == y);
  assign G = (x > y);
  assign L = (x < y);

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial WIDTH-bit magnitude comparator, MSB-first, DIGIT bits per clock.
// A start pulse (accepted in IDLE or DONE) loads a/b/signed_mode; the FSM walks the digits
// through one shared digit_cmp and pulses done for one cycle with the result on E/not_E/G/L.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, sampled only in IDLE or DONE
//   signed_mode         : 1 = two's-complement operands (sampled with start)
//   a, b                : operands (sampled with start)
//   busy                : high while comparing
//   done                : one-cycle result-valid pulse
//   E, not_E, G, L      : registered result, held until the next done or reset
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 1,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             not_E,
  output logic             G,
  output logic             L
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  cmp_res_t         first_q, first_d;  // result of the first unequal digit
  cmp_res_t         res_q, res_d;

  logic     dig_e, dig_g, dig_l;
  cmp_res_t dig_res;
  logic     load;

  digit_cmp #(
    .DIGIT(DIGIT)
  ) u_digit_cmp (
    .x(sa_q[WIDTH-1 -: DIGIT]),
    .y(sb_q[WIDTH-1 -: DIGIT]),
    .E(dig_e),
    .G(dig_g),
    .L(dig_l)
  );

  assign dig_res = '{e: dig_e, g: dig_g, l: dig_l};
  assign load    = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    first_d   = first_q;
    res_d     = res_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        sa_d  = sa_q << DIGIT;
        sb_d  = sb_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        // Only the first unequal digit decides; later digits are don't-care.
        if (!decided_q && !dig_e) begin
          decided_d = 1'b1;
          first_d   = dig_res;
        end
        if ((EARLY_EXIT != 0) && !dig_e) begin
          res_d   = dig_res;
          state_d = StDone;
        end else if (cnt_q == '0) begin
          res_d   = decided_q ? first_q : dig_res;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = start ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      // Flipping the sign bit maps two's complement onto offset binary, so the
      // unsigned digit compare orders signed operands correctly.
      sa_d            = a;
      sb_d            = b;
      sa_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
      sb_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
      cnt_d           = CNT_W'(NDIG - 1);
      decided_d       = 1'b0;
      first_d         = ResEqual;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      first_q   <= ResEqual;
      res_q     <= ResEqual;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      first_q   <= first_d;
      res_q     <= res_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign E     = res_q.e;
  assign not_E = ~res_q.e;
  assign G     = res_q.g;
  assign L     = res_q.l;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: three instances (DIGIT=1 fixed latency, DIGIT=1 early exit,
// DIGIT=4 early exit) driven with the same operands and checked against an arithmetic model.
module tb_serial_mag_comparator;

  logic       clk;
  logic       reset;
  logic       start;
  logic       signed_mode;
  logic [7:0] a, b;
  logic [2:0] busy_w, done_w, e_w, ne_w, g_w, l_w;

  int n_vec = 0;
  int n_err = 0;
  int dig_of[3] = '{1, 1, 4};
  int ee_of[3]  = '{0, 1, 1};
  logic [3:0] prev[3];  // last result per instance as {E,not_E,G,L}

  serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u_d1_fixed (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .E(e_w[0]), .not_E(ne_w[0]), .G(g_w[0]), .L(l_w[0])
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u_d1_early (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .E(e_w[1]), .not_E(ne_w[1]), .G(g_w[1]), .L(l_w[1])
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(1)) u_d4_early (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_w[2]), .done(done_w[2]), .E(e_w[2]), .not_E(ne_w[2]), .G(g_w[2]), .L(l_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs(input int i);
    return {e_w[i], ne_w[i], g_w[i], l_w[i]};
  endfunction

  // Reference result {E,not_E,G,L} from plain integer comparison.
  function automatic logic [3:0] ref_cmp(input logic [7:0] oa, input logic [7:0] ob,
                                         input logic osm);
    logic gt, lt;
    if (osm) begin
      gt = $signed(oa) > $signed(ob);
      lt = $signed(oa) < $signed(ob);
    end else begin
      gt = oa > ob;
      lt = oa < ob;
    end
    return {oa == ob, oa != ob, gt, lt};
  endfunction

  // Cycles from the start-sampling edge (counted as 1) to the first cycle done is seen.
  function automatic int ref_lat(input logic [7:0] oa, input logic [7:0] ob, input logic osm,
                                 input int i);
    logic [7:0] diff;
    int p;
    int ndig;
    diff = oa ^ ob;  // sign-bit flip affects both operands alike
    p = -1;
    for (int k = 7; k >= 0; k--) if (diff[k] && p < 0) p = k;
    ndig = 8 / dig_of[i];
    if (ee_of[i] == 0 || p < 0) return ndig + 1;
    return (7 - p) / dig_of[i] + 2;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) prev[i] = 4'b1000;
  endtask

  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic osm,
                       input string tag);
    logic [3:0] exp_r;
    int exp_lat[3];
    bit got[3];
    exp_r = ref_cmp(oa, ob, osm);
    for (int i = 0; i < 3; i++) begin
      exp_lat[i] = ref_lat(oa, ob, osm, i);
      got[i] = 1'b0;
    end
    @(negedge clk);
    a = oa; b = ob; signed_mode = osm; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!got[i]) begin
          if (done_w[i]) begin
            got[i] = 1'b1;
            n_vec++;
            if (n != exp_lat[i]) begin
              n_err++;
              $display("FAIL %s latency inst%0d a=%h b=%h s=%0d: got %0d expected %0d",
                       tag, i, oa, ob, osm, n, exp_lat[i]);
            end
            n_vec++;
            if (outs(i) !== exp_r) begin
              n_err++;
              $display("FAIL %s result inst%0d a=%h b=%h s=%0d: got %b expected %b",
                       tag, i, oa, ob, osm, outs(i), exp_r);
            end
            prev[i] = exp_r;
          end else begin
            n_vec++;
            if ({busy_w[i], outs(i)} !== {1'b1, prev[i]}) begin
              n_err++;
              $display("FAIL %s hold inst%0d cycle %0d: got %b expected %b",
                       tag, i, n, {busy_w[i], outs(i)}, {1'b1, prev[i]});
            end
          end
        end else begin
          n_vec++;
          if (done_w[i] !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse inst%0d cycle %0d: got %b expected 0", tag, i, n, done_w[i]);
          end
        end
      end
      if (got[0] && got[1] && got[2]) break;
      // Operands are free to change once loaded.
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      signed_mode = 1'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      if (!got[i]) begin
        n_vec++;
        n_err++;
        $display("FAIL %s timeout inst%0d: got no done expected done", tag, i);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy_w, done_w} !== 6'b0) begin
      n_err++;
      $display("FAIL %s idle: got busy=%b done=%b expected 000/000", tag, busy_w, done_w);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({busy_w[i], done_w[i], outs(i)} !== 6'b001000) begin
        n_err++;
        $display("FAIL reset inst%0d: got %b expected 001000", i,
                 {busy_w[i], done_w[i], outs(i)});
      end
      prev[i] = 4'b1000;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fixed_latency();
    do_op(8'h5A, 8'h5B, 1'b0, "unsigned_5a_5b");
  endtask

  task automatic test_early_exit();
    do_op(8'h80, 8'h7F, 1'b0, "early_unsigned");
    do_op(8'h80, 8'h7F, 1'b1, "early_signed");
  endtask

  task automatic test_equal_signed();
    do_op(8'hC3, 8'hC3, 1'b1, "equal_signed");
  endtask

  task automatic test_back_to_back();
    logic [16:0] pr[5];
    bit got;
    for (int i = 0; i < 5; i++) pr[i] = {1'($urandom), 8'($urandom), 8'($urandom)};
    pr[1][7:0] = pr[1][15:8];  // include an equal pair
    @(negedge clk);
    {signed_mode, a, b} = pr[0];
    start = 1'b1;
    for (int op = 0; op < 5; op++) begin
      got = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        // c == 1 is the load edge of this op: present the next pair right away.
        if (c == 1) begin
          if (op + 1 < 5) {signed_mode, a, b} = pr[op + 1];
          else start = 1'b0;
        end
        if (done_w[0]) begin
          got = 1'b1;
          n_vec++;
          if (c != 9) begin
            n_err++;
            $display("FAIL b2b period op%0d: got %0d expected 9", op, c);
          end
          n_vec++;
          if (outs(0) !== ref_cmp(pr[op][15:8], pr[op][7:0], pr[op][16])) begin
            n_err++;
            $display("FAIL b2b result op%0d: got %b expected %b", op, outs(0),
                     ref_cmp(pr[op][15:8], pr[op][7:0], pr[op][16]));
          end
          break;
        end
      end
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL b2b timeout op%0d: got no done expected done", op);
      end
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 8'h3C; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy_w !== 3'b111) begin
      n_err++;
      $display("FAIL midrun busy: got %b expected 111", busy_w);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({busy_w[i], done_w[i], outs(i)} !== 6'b001000) begin
        n_err++;
        $display("FAIL midrun reset inst%0d: got %b expected 001000", i,
                 {busy_w[i], done_w[i], outs(i)});
      end
      prev[i] = 4'b1000;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({busy_w, done_w} !== 6'b0) begin
        n_err++;
        $display("FAIL midrun quiet cycle %0d: got busy=%b done=%b expected 000/000",
                 c, busy_w, done_w);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] oa, ob;
    logic osm;
    for (int t = 0; t < 3000; t++) begin
      oa = 8'($urandom);
      osm = 1'($urandom);
      case ($urandom_range(2, 0))
        0: ob = 8'($urandom);
        1: ob = oa;
        default: ob = oa ^ (8'd1 << $urandom_range(7, 0));
      endcase
      do_op(oa, ob, osm, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_early_exit();
    test_equal_signed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
